stream_mux_3port: RTL
=====================

STREAM_MUX_3PORT -- requirements
Module: stream_mux_3port

Interface
REQ-001 Parameter: DATA_W, default 8, data width of every stream port.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 inN_valid  input  1  port N (N=0,1,2) beat valid.
REQ-005 inN_data  input  DATA_W  port N beat data.
REQ-006 inN_last  input  1  port N final beat of packet.
REQ-007 inN_ready  output  1  port N beat accepted when valid&ready.
REQ-008 out_valid  output  1  registered output beat valid.
REQ-009 out_data  output  DATA_W  registered output data.
REQ-010 out_last  output  1  registered output last flag.
REQ-011 out_ready  input  1  downstream accepts out beat when valid&ready.
REQ-012 arb_req  output  3  bit N = inN_valid, combinational, to round-robin arbiter request inputs.
REQ-013 arb_ce  output  1  one-cycle arbiter advance strobe.
REQ-014 arb_grant  input  2  arbiter grant index, updated at the clk edge where arb_ce=1.

Function
REQ-015 The block SHALL implement FSM states IDLE, ARB, STREAM, encoded in 2 bits.
REQ-016 IDLE: if any inN_valid=1, SHALL assert arb_ce=1 this cycle and go to ARB; else stay IDLE with arb_ce=0.
REQ-017 arb_ce SHALL be 1 only in IDLE with any valid; 0 in ARB and STREAM.
REQ-018 ARB: if arb_grant<=2 and in[arb_grant]_valid=1, SHALL latch sel=arb_grant and go to STREAM; otherwise (grant=3 or granted port idle) return to IDLE.
REQ-019 STREAM: in[sel]_ready SHALL equal (~out_valid | out_ready); all other inN_ready SHALL be 0.
REQ-020 inN_ready SHALL be 0 for all N in IDLE and ARB.
REQ-021 On an accepted beat (in[sel]_valid & in[sel]_ready), out_data/out_last SHALL load the beat and out_valid SHALL be 1 next cycle (1-cycle latency).
REQ-022 When out_valid=1 and out_ready=1 with no new beat accepted, out_valid SHALL clear next cycle.
REQ-023 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Accepted beat with in[sel]_last=1 SHALL move FSM to IDLE next cycle; sel stays fixed for the whole packet.
REQ-025 A new packet MAY start arbitration in IDLE while the final beat is still held in the output register.
REQ-026 Sustained throughput within a packet SHALL be 1 beat/cycle with out_ready=1; packet-to-packet gap SHALL be 2 cycles (IDLE, ARB) with no input accepted.
REQ-027 inN_valid changes on non-selected ports SHALL not affect sel during STREAM.
REQ-028 Beats SHALL be neither duplicated nor dropped; output order equals acceptance order.

Reset
REQ-029 While rst=1: state=IDLE, sel=0, out_valid=0, out_data=0, out_last=0, arb_ce=0, all inN_ready=0.
REQ-030 Reset asserted mid-packet SHALL discard the held beat and remaining packet state; first cycle after release is IDLE.

Verification
REQ-031 Single port: in1 sends 3-beat packet (A1,A2,A3), arb_grant 0->1, out_ready=1 -> arb_ce pulse 1 cycle, in1_ready high 2 cycles after valid, out beats A1,A2,A3 on consecutive cycles, out_last on A3.
REQ-032 Contention: all three ports valid with 2-beat packets, arbiter starting grant=0 -> output packet order 1,2,0, each packet contiguous, 2-cycle gap between packets.
REQ-033 Backpressure: out_ready=0 for 4 cycles mid-packet -> out_data stable, in[sel]_ready=0, no beat lost; resumes 1 beat/cycle on out_ready=1.
REQ-034 Invalid grant: arb_grant=3 in ARB -> FSM returns to IDLE, no ready asserted, arb_ce re-pulses next cycle.
REQ-035 Reset mid-packet: rst=1 after beat 2 of 4 -> out_valid=0 immediately, IDLE after release, new packet from port 2 forwarded correctly.
REQ-036 Single-beat packets back-to-back on in0 (grant held 0) -> each beat forwarded, arb_ce pulses once per packet.

Source files
------------

// File: rtl/stream_mux_3port_if.sv
// stream_mux_3port_if: one valid/ready stream port carrying data plus an end-of-packet flag
interface stream_mux_3port_if #(
    parameter int DATA_W = 8
) ();
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ready;
    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/stream_mux_3port.sv
// stream_mux_3port: packet-granular 3:1 stream mux; an external round-robin arbiter picks the port,
// the packet is then forwarded through a single registered output stage.
module stream_mux_3port #(
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    stream_mux_3port_if.slave  in0_i,
    stream_mux_3port_if.slave  in1_i,
    stream_mux_3port_if.slave  in2_i,
    stream_mux_3port_if.master out_o,
    output logic [2:0]         arb_req_o,
    output logic               arb_ce_o,
    input  logic [1:0]         arb_grant_i
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, STREAM = 2'd2} state_e;
    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [3:0]        valid_x;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last, can_load, take;
    // bit 3 stands in for the invalid grant index so it never looks like a live request
    assign valid_x   = {1'b0, in2_i.valid, in1_i.valid, in0_i.valid};
    assign arb_req_o = valid_x[2:0];
    assign sel_data  = sel_q == 2'd2 ? in2_i.data : sel_q == 2'd1 ? in1_i.data : in0_i.data;
    assign sel_last  = sel_q == 2'd2 ? in2_i.last : sel_q == 2'd1 ? in1_i.last : in0_i.last;
    assign can_load  = ~out_valid_q | out_o.ready;
    assign take      = state_q == STREAM && valid_x[sel_q] && can_load;
    assign in0_i.ready = state_q == STREAM && sel_q == 2'd0 && can_load;
    assign in1_i.ready = state_q == STREAM && sel_q == 2'd1 && can_load;
    assign in2_i.ready = state_q == STREAM && sel_q == 2'd2 && can_load;
    assign out_o.valid = out_valid_q;
    assign out_o.data  = out_data_q;
    assign out_o.last  = out_last_q;
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        arb_ce_o = 1'b0;
        case (state_q)
            IDLE: begin
                arb_ce_o = |valid_x & ~rst;
                state_d  = |valid_x ? ARB : IDLE;
            end
            ARB: begin
                state_d = valid_x[arb_grant_i] ? STREAM : IDLE;
                sel_d   = valid_x[arb_grant_i] ? arb_grant_i : sel_q;
            end
            STREAM:  state_d = take && sel_last ? IDLE : STREAM;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        out_valid_d = take | (out_valid_q & ~out_o.ready);
        out_data_d  = take ? sel_data : out_data_q;
        out_last_d  = take ? sel_last : out_last_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule
